// File: rtl/man_align_pipe.sv
// FPU add/sub pre-alignment: order operands, align smaller mantissa.
// Option: FP_ALIGN_SUBNORM_EN keeps subnormals (else flushed to zero).
module man_align_pipe #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_FRAC = 23,
  parameter int SIZE_MAN  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [SIZE_EXP+SIZE_FRAC:0] i_a,
  input  logic [SIZE_EXP+SIZE_FRAC:0] i_b,
  input  logic                        i_sub,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [SIZE_EXP-1:0]         o_exp,
  output logic                        o_sign_big,
  output logic                        o_eff_sub,
  output logic                        o_swap,
  output logic [SIZE_MAN-1:0]         o_man_big,
  output logic [SIZE_MAN-1:0]         o_man_small
);

  localparam int EW  = SIZE_EXP;
  localparam int FW  = SIZE_FRAC;
  localparam int MW  = SIZE_MAN;
  localparam int PAD = MW - FW - 1;

  typedef struct packed {
    logic          sign_big;
    logic          eff_sub;
    logic          swap;
    logic [EW-1:0] exp;
    logic [EW-1:0] d;
    logic          hid_big;
    logic [FW-1:0] frac_big;
    logic          hid_small;
    logic [FW-1:0] frac_small;
  } s1_t;

  typedef struct packed {
    logic [EW-1:0] exp;
    logic          sign_big;
    logic          eff_sub;
    logic          swap;
    logic [MW-1:0] man_big;
    logic [MW-1:0] man_small;
  } s2_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s2_load, in_fire;

  logic [EW-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [FW-1:0] frac_a, frac_b;
  logic          hid_a, hid_b, sign_a, sign_b, swap;

  logic [MW-1:0]   m_big, m_small, sm;
  logic [2*MW-1:0] ext;

  assign s2_load = ~s2_valid_q | i_ready;
  assign o_ready = i_rst_n & (~s1_valid_q | s2_load);
  assign in_fire = i_valid & o_ready;

  // S1: unpack, order by magnitude, exponent difference
  always_comb begin
    exp_a  = i_a[EW+FW-1:FW];
    exp_b  = i_b[EW+FW-1:FW];
    frac_a = i_a[FW-1:0];
    frac_b = i_b[FW-1:0];
    hid_a  = |exp_a;
    hid_b  = |exp_b;
    eexp_a = exp_a;
    eexp_b = exp_b;
`ifdef FP_ALIGN_SUBNORM_EN
    if (!hid_a) eexp_a = EW'(1);
    if (!hid_b) eexp_b = EW'(1);
`else
    if (!hid_a) frac_a = '0;
    if (!hid_b) frac_b = '0;
`endif
    sign_a = i_a[EW+FW];
    sign_b = i_b[EW+FW] ^ i_sub;
    swap   = {exp_b, frac_b} > {exp_a, frac_a};
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (o_ready) s1_valid_d = i_valid;
    if (in_fire) begin
      s1_d.swap       = swap;
      s1_d.sign_big   = swap ? sign_b : sign_a;
      s1_d.eff_sub    = sign_a ^ sign_b;
      s1_d.exp        = swap ? exp_b : exp_a;
      s1_d.d          = swap ? eexp_b - eexp_a
                             : eexp_a - eexp_b;
      s1_d.hid_big    = swap ? hid_b : hid_a;
      s1_d.frac_big   = swap ? frac_b : frac_a;
      s1_d.hid_small  = swap ? hid_a : hid_b;
      s1_d.frac_small = swap ? frac_a : frac_b;
    end
  end

  // S2: build mantissas, shift smaller one with sticky fold
  always_comb begin
    m_big   = {s1_q.hid_big, s1_q.frac_big,
               {PAD{1'b0}}};
    m_small = {s1_q.hid_small, s1_q.frac_small,
               {PAD{1'b0}}};
    ext = {m_small, {MW{1'b0}}} >> s1_q.d;
    if (s1_q.d >= EW'(MW))
      sm = {{(MW-1){1'b0}}, |m_small};
    else
      sm = ext[2*MW-1:MW]
         | {{(MW-1){1'b0}}, |ext[MW-1:0]};
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.exp       = s1_q.exp;
        s2_d.sign_big  = s1_q.sign_big;
        s2_d.eff_sub   = s1_q.eff_sub;
        s2_d.swap      = s1_q.swap;
        s2_d.man_big   = m_big;
        s2_d.man_small = sm;
      end
    end
  end

  // Pipeline registers; reset drops all in-flight bundles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_exp       = s2_q.exp;
  assign o_sign_big  = s2_q.sign_big;
  assign o_eff_sub   = s2_q.eff_sub;
  assign o_swap      = s2_q.swap;
  assign o_man_big   = s2_q.man_big;
  assign o_man_small = s2_q.man_small;

endmodule
